// File: rtl/mcash_rst_pkg.sv
// mcash_rst_pkg: sequencer state encoding and default parameter values.
package mcash_rst_pkg;
    typedef enum logic [1:0] {HOLD, RELEASE, RUN, SOFT} state_e;
    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_STAGE_DLY   = 8;
    localparam int DEF_SOFT_HOLD   = 4;
    localparam int DEF_TIMEOUT_CYC = 1000;
    localparam int DEF_CYC_W       = 32;
endpackage

// File: rtl/mcash_rst_seq_if.sv
// mcash_rst_seq_if: soft-reset handshake and per-domain reset/status bundle.
interface mcash_rst_seq_if #(
    parameter int NUM_CH = 4,
    parameter int CYC_W  = 32
);
    logic              soft_rst_req_i;
    logic              soft_rst_ack_o;
    logic [NUM_CH-1:0] ch_rst_no;
    logic              rst_done_o;
    logic [CYC_W-1:0]  cycle_cnt_o;
    logic              timeout_o;
    modport master (
        input  soft_rst_req_i,
        output soft_rst_ack_o, ch_rst_no, rst_done_o, cycle_cnt_o, timeout_o
    );
    modport slave (
        output soft_rst_req_i,
        input  soft_rst_ack_o, ch_rst_no, rst_done_o, cycle_cnt_o, timeout_o
    );
endinterface

// File: rtl/mcash_rst_sync.sv
// mcash_rst_sync: async-assert, sync-deassert reset synchroniser.
module mcash_rst_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic rst_sync_no
);
    logic [SYNC_STAGES-1:0] q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) q <= '0;
        else         q <= {q[SYNC_STAGES-2:0], 1'b1};
    end
    assign rst_sync_no = q[SYNC_STAGES-1];
endmodule

// File: rtl/mcash_rst_seq.sv
// mcash_rst_seq: staggered multi-domain reset release with soft-reset handshake and run timeout.
module mcash_rst_seq
    import mcash_rst_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int STAGE_DLY   = DEF_STAGE_DLY,
    parameter int SOFT_HOLD   = DEF_SOFT_HOLD,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int CYC_W       = DEF_CYC_W
) (
    input logic             clk_i,
    input logic             rst_ni,
    mcash_rst_seq_if.master bus
);
    localparam int CW = $clog2(STAGE_DLY) + 1;
    localparam int IW = $clog2(NUM_CH) + 1;
    localparam int HW = $clog2(SOFT_HOLD) + 1;
    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [NUM_CH-1:0] ch_q, ch_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic              ack_q, ack_d, done_q, done_d, to_q, to_d;
    logic              rst_sync_n;
    logic              req;
    assign req = bus.soft_rst_req_i;
    mcash_rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rst_sync_no (rst_sync_n)
    );
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        ch_d    = ch_q;
        cyc_d   = cyc_q;
        ack_d   = ack_q;
        done_d  = done_q;
        to_d    = to_q;
        case (state_q)
            HOLD: if (rst_sync_n) begin
                state_d = RELEASE;
                idx_d   = '0;
                cnt_d   = '0;
            end
            RELEASE: if (cnt_q == CW'(STAGE_DLY - 1)) begin
                ch_d  = ch_q | (NUM_CH'(1) << idx_q);
                idx_d = idx_q + 1'b1;
                cnt_d = '0;
                if (idx_q == IW'(NUM_CH - 1)) state_d = RUN;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            RUN: if (req) begin
                state_d = SOFT;
                ch_d    = '0;
                done_d  = 1'b0;
                ack_d   = 1'b1;
                cyc_d   = '0;
                to_d    = 1'b0;
                hold_d  = '0;
            end else begin
                done_d = 1'b1;
                cyc_d  = &cyc_q ? cyc_q : cyc_q + 1'b1;
                to_d   = to_q | (TIMEOUT_CYC != 0 && cyc_d == CYC_W'(TIMEOUT_CYC));
            end
            // hold counter saturates one short of SOFT_HOLD so ack spans exactly SOFT_HOLD edges
            SOFT: if (hold_q == HW'(SOFT_HOLD - 1) && !req) begin
                state_d = RELEASE;
                ack_d   = 1'b0;
                idx_d   = '0;
                cnt_d   = '0;
            end else if (hold_q != HW'(SOFT_HOLD - 1)) begin
                hold_d = hold_q + 1'b1;
            end
            default: state_d = HOLD;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            ch_q    <= '0;
            cyc_q   <= '0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            ch_q    <= ch_d;
            cyc_q   <= cyc_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            to_q    <= to_d;
        end
    end
    assign bus.ch_rst_no      = ch_q;
    assign bus.soft_rst_ack_o = ack_q;
    assign bus.rst_done_o     = done_q;
    assign bus.cycle_cnt_o    = cyc_q;
    assign bus.timeout_o      = to_q;
endmodule

// File: tb/tb_mcash_rst_seq.sv
// tb_mcash_rst_seq: edge-numbered directed vectors for power-on, soft reset, timeout and async abort.
module tb_mcash_rst_seq;
    typedef struct {
        int         e;
        logic       req;
        logic [3:0] ch;
        logic       done;
        logic       ack;
        int         cyc;
        logic       to;
    } vec_t;
    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    int   ecnt = 0;
    int   base = 0;
    int   errors = 0;
    int   checks = 0;
    vec_t tbl[$];
    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;
    mcash_rst_seq_if #(.NUM_CH(4), .CYC_W(32)) bus ();
    mcash_rst_seq #(
        .NUM_CH(4), .SYNC_STAGES(2), .STAGE_DLY(8),
        .SOFT_HOLD(4), .TIMEOUT_CYC(100), .CYC_W(32)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );
    task automatic add(int e, logic req, logic [3:0] ch, logic d, logic a, int c, logic t);
        vec_t v;
        v = '{e, req, ch, d, a, c, t};
        tbl.push_back(v);
    endtask
    task automatic goto(int e);
        while (ecnt < base + e) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic chk(string name, int e, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got %0h want %0h", name, e, act, exp);
        end
    endtask
    task automatic chk_all(string tag, int e, logic [3:0] ch, logic d, logic a, int c, logic t);
        chk({tag, ".ch"}, e, 32'(bus.ch_rst_no), 32'(ch));
        chk({tag, ".done"}, e, 32'(bus.rst_done_o), 32'(d));
        chk({tag, ".ack"}, e, 32'(bus.soft_rst_ack_o), 32'(a));
        chk({tag, ".cyc"}, e, bus.cycle_cnt_o, c);
        chk({tag, ".to"}, e, 32'(bus.timeout_o), 32'(t));
    endtask
    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    initial begin
        bus.soft_rst_req_i = 1'b0;
        // power-on release and timeout
        add(1, 0, 4'b0000, 0, 0, 0, 0);
        add(2, 0, 4'b0000, 0, 0, 0, 0);
        add(3, 0, 4'b0000, 0, 0, 0, 0);
        add(10, 0, 4'b0000, 0, 0, 0, 0);
        add(11, 0, 4'b0001, 0, 0, 0, 0);
        add(18, 0, 4'b0001, 0, 0, 0, 0);
        add(19, 0, 4'b0011, 0, 0, 0, 0);
        add(26, 0, 4'b0011, 0, 0, 0, 0);
        add(27, 0, 4'b0111, 0, 0, 0, 0);
        add(34, 0, 4'b0111, 0, 0, 0, 0);
        add(35, 0, 4'b1111, 0, 0, 0, 0);
        add(36, 0, 4'b1111, 1, 0, 1, 0);
        add(134, 0, 4'b1111, 1, 0, 99, 0);
        add(135, 0, 4'b1111, 1, 0, 100, 1);
        add(140, 1, 4'b1111, 1, 0, 105, 1);
        // long soft-reset request, 20 edges
        add(141, 1, 4'b0000, 0, 1, 0, 0);
        add(160, 0, 4'b0000, 0, 1, 0, 0);
        add(161, 0, 4'b0000, 0, 0, 0, 0);
        add(168, 0, 4'b0000, 0, 0, 0, 0);
        add(169, 0, 4'b0001, 0, 0, 0, 0);
        add(193, 0, 4'b1111, 0, 0, 0, 0);
        add(194, 1, 4'b1111, 1, 0, 1, 0);
        // one-cycle request still gets the full hold
        add(195, 0, 4'b0000, 0, 1, 0, 0);
        add(198, 0, 4'b0000, 0, 1, 0, 0);
        add(199, 0, 4'b0000, 0, 0, 0, 0);
        // request raised during release waits for the first run edge
        add(200, 1, 4'b0000, 0, 0, 0, 0);
        add(207, 1, 4'b0001, 0, 0, 0, 0);
        add(231, 1, 4'b1111, 0, 0, 0, 0);
        add(232, 0, 4'b0000, 0, 1, 0, 0);
        add(233, 0, 4'b0000, 0, 1, 0, 0);
        add(236, 0, 4'b0000, 0, 0, 0, 0);
        add(244, 0, 4'b0001, 0, 0, 0, 0);
        add(268, 0, 4'b1111, 0, 0, 0, 0);
        add(269, 0, 4'b1111, 1, 0, 1, 0);
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 0, 4'b0000, 0, 0, 0, 0);
        @(negedge clk);
        rst_ni = 1'b1;
        base = ecnt;
        foreach (tbl[i]) begin
            goto(tbl[i].e);
            chk_all("tbl", tbl[i].e, tbl[i].ch, tbl[i].done, tbl[i].ack, tbl[i].cyc, tbl[i].to);
            bus.soft_rst_req_i = tbl[i].req;
        end
        rst_ni = 1'b0;
        #2;
        chk_all("async_run", 0, 4'b0000, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        base = ecnt;
        goto(20);
        chk_all("pre_abort", 20, 4'b0011, 0, 0, 0, 0);
        #2 rst_ni = 1'b0;
        #2;
        chk_all("abort", 20, 4'b0000, 0, 0, 0, 0);
        #1 rst_ni = 1'b1;
        base = ecnt;
        goto(10);
        chk_all("restart", 10, 4'b0000, 0, 0, 0, 0);
        goto(11);
        chk_all("restart", 11, 4'b0001, 0, 0, 0, 0);
        goto(35);
        chk_all("restart", 35, 4'b1111, 0, 0, 0, 0);
        goto(36);
        chk_all("restart", 36, 4'b1111, 1, 0, 1, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
